// File: rtl/sample_gate_sched_pkg.sv
// rtl/sample_gate_sched_pkg.sv - shared types and defaults for the sample gate scheduler
//   gate_state_t   : IDLE / ARMED / STREAM state encoding
//   DEFAULT_DIV_W  : default decimation divider width
//   DEFAULT_DROP_W : default drop counter width
package sample_gate_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        STREAM = 2'd2
    } gate_state_t;

    localparam int DEFAULT_DIV_W  = 24;
    localparam int DEFAULT_DROP_W = 16;

endpackage

// File: rtl/sample_gate_sched_toggle_sync.sv
// rtl/sample_gate_sched_toggle_sync.sv - toggle synchronizer with edge pulse output
//   sampleClock : destination clock
//   extReset    : asynchronous active-high reset
//   toggle      : level-change request from the other clock domain
//   edge_pulse  : one-cycle pulse per level change, combinational from the last flop pair
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sampleClock,
    input  logic extReset,
    input  logic toggle,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   last_q;

    always_ff @(posedge sampleClock or posedge extReset) begin
        if (extReset) begin
            chain  <= '0;
            last_q <= 1'b0;
        end else begin
            chain  <= {chain[SYNC_STAGES-2:0], toggle};
            last_q <= chain[SYNC_STAGES-1];
        end
    end

    // Left combinational so a toggle change acts on state SYNC_STAGES+1 edges later.
    assign edge_pulse = chain[SYNC_STAGES-1] ^ last_q;

endmodule

// File: rtl/sample_gate_sched.sv
// rtl/sample_gate_sched.sv - arms, decimates and gates sample writes into the async FIFO
//   sampleClock, extReset     : sample clock, asynchronous active-high reset
//   arm_toggle, stop_toggle   : core-domain requests, one request per level change
//   divider                   : a sample is taken every divider+1 STREAM cycles
//   indata, space_avail       : synchronized sample, FIFO can accept a write
//   wrenb, wrdata             : registered FIFO write port
//   arm_ack_toggle            : flips once per accepted arm
//   overflow, drop_count      : sticky drop flag and saturating drop count since last arm
//   state                     : current state for status readback
module sample_gate_sched
    import sample_gate_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = DEFAULT_DIV_W,
    parameter int DROP_W      = DEFAULT_DROP_W
) (
    input  logic              sampleClock,
    input  logic              extReset,
    input  logic              arm_toggle,
    input  logic              stop_toggle,
    input  logic [DIV_W-1:0]  divider,
    input  logic [31:0]       indata,
    input  logic              space_avail,
    output logic              wrenb,
    output logic [31:0]       wrdata,
    output logic              arm_ack_toggle,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count,
    output logic [1:0]        state
);

    logic        arm_edge;
    logic        stop_edge;
    gate_state_t cur_state;
    logic [DIV_W-1:0] div_cnt;

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_arm_sync (
        .sampleClock (sampleClock),
        .extReset    (extReset),
        .toggle      (arm_toggle),
        .edge_pulse  (arm_edge)
    );

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stop_sync (
        .sampleClock (sampleClock),
        .extReset    (extReset),
        .toggle      (stop_toggle),
        .edge_pulse  (stop_edge)
    );

    always_ff @(posedge sampleClock or posedge extReset) begin
        if (extReset) begin
            cur_state      <= IDLE;
            div_cnt        <= '0;
            wrenb          <= 1'b0;
            wrdata         <= 32'd0;
            arm_ack_toggle <= 1'b0;
            overflow       <= 1'b0;
            drop_count     <= '0;
        end else if (stop_edge) begin
            // Stop outranks a coincident arm; drop status is kept for readback.
            cur_state <= IDLE;
            div_cnt   <= '0;
            wrenb     <= 1'b0;
        end else if (arm_edge) begin
            cur_state      <= ARMED;
            div_cnt        <= '0;
            wrenb          <= 1'b0;
            overflow       <= 1'b0;
            drop_count     <= '0;
            arm_ack_toggle <= ~arm_ack_toggle;
        end else begin
            case (cur_state)
                IDLE: begin
                    wrenb <= 1'b0;
                end
                ARMED: begin
                    wrenb <= 1'b0;
                    if (space_avail) begin
                        cur_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (div_cnt == divider) begin
                        div_cnt <= '0;
                        if (space_avail) begin
                            wrenb  <= 1'b1;
                            wrdata <= indata;
                        end else begin
                            wrenb    <= 1'b0;
                            overflow <= 1'b1;
                            if (!(&drop_count)) begin
                                drop_count <= drop_count + DROP_W'(1);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                        wrenb   <= 1'b0;
                    end
                end
                default: begin
                    cur_state <= IDLE;
                    wrenb     <= 1'b0;
                end
            endcase
        end
    end

    assign state = cur_state;

endmodule
